// File: rtl/seq_det_ctrl.sv
// Run controller for a programmable PAT_W-bit Mealy pattern detector with hit
// threshold and cycle window. Optional interrupt port: define SEQ_DET_IRQ_EN.
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             w_i,
  input  logic             w_valid_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic             overlap_i,
  input  logic [CNT_W-1:0] hit_thresh_i,
  input  logic [WIN_W-1:0] window_i,
`ifdef SEQ_DET_IRQ_EN
  input  logic             irq_clr_i,
  output logic             irq_o,
`endif
  output logic             z_o,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o
);

  localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q,   state_d;
  logic [PAT_W-1:0]   pat_q,     pat_d;
  logic               overlap_q, overlap_d;
  logic [CNT_W-1:0]   thresh_q,  thresh_d;
  logic [WIN_W-1:0]   win_q,     win_d;
  logic [WIN_W-1:0]   timer_q,   timer_d;
  logic [PAT_W-2:0]   hist_q,    hist_d;
  logic [FILL_W-1:0]  fill_q,    fill_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic               timeout_q, timeout_d;

  logic [PAT_W-1:0]   shifted;
  logic [CNT_W-1:0]   hit_inc;
  logic               match;
  logic               expire;

  // The newest bit joins the history; this is both the compare word and,
  // truncated, the next history.
  assign shifted = {hist_q, w_i};
  assign match   = (state_q == RUN) && w_valid_i && (fill_q == FILL_MAX) &&
                   (shifted == pat_q);
  assign hit_inc = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
  assign expire  = (win_q != '0) && (timer_q == WIN_W'(1));

  // NOTE: every signal assigned below gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    overlap_d = overlap_q;
    thresh_d  = thresh_q;
    win_d     = win_q;
    timer_d   = timer_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    hit_cnt_d = hit_cnt_q;
    timeout_d = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          pat_d     = pattern_i;
          overlap_d = overlap_i;
          thresh_d  = hit_thresh_i;
          win_d     = window_i;
          timer_d   = window_i;
          hist_d    = '0;
          fill_d    = '0;
          hit_cnt_d = '0;
          timeout_d = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (w_valid_i) begin
          hist_d = shifted[PAT_W-2:0];
          if (match && !overlap_q)    fill_d = '0;
          else if (fill_q != FILL_MAX) fill_d = fill_q + FILL_W'(1);
        end
        if (win_q != '0) timer_d = timer_q - WIN_W'(1);

        if (abort_i) begin
          timeout_d = 1'b0;
          state_d   = IDLE;
        end else begin
          if (match) hit_cnt_d = hit_inc;
          // Threshold outranks window expiry when both land on one cycle.
          if (match && (thresh_q != '0) && (hit_inc == thresh_q)) begin
            timeout_d = 1'b0;
            state_d   = DONE;
          end else if (expire) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      overlap_q <= 1'b0;
      thresh_q  <= '0;
      win_q     <= '0;
      timer_q   <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      hit_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      overlap_q <= overlap_d;
      thresh_q  <= thresh_d;
      win_q     <= win_d;
      timer_q   <= timer_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      hit_cnt_q <= hit_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign z_o       = match;
  assign hit_cnt_o = hit_cnt_q;
  assign busy_o    = (state_q == RUN);
  assign done_o    = (state_q == DONE);
  assign timeout_o = timeout_q;

`ifdef SEQ_DET_IRQ_EN
  logic irq_q;

  // A done pulse sets the flag even if a clear arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          irq_q <= 1'b0;
    else if (done_o)     irq_q <= 1'b1;
    else if (irq_clr_i)  irq_q <= 1'b0;
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Table-driven self-checking bench for seq_det_ctrl, plus hand-written
// sequences for asynchronous reset mid-run and the optional interrupt.
module tb_seq_det_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, abort_i, w_i, w_valid_i, overlap_i;
  logic [3:0]  pattern_i;
  logic [7:0]  hit_thresh_i;
  logic [15:0] window_i;
  logic        z_o, busy_o, done_o, timeout_o;
  logic [7:0]  hit_cnt_o;
`ifdef SEQ_DET_IRQ_EN
  logic        irq_clr_i;
  logic        irq_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.PAT_W(4), .CNT_W(8), .WIN_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .w_i          (w_i),
    .w_valid_i    (w_valid_i),
    .pattern_i    (pattern_i),
    .overlap_i    (overlap_i),
    .hit_thresh_i (hit_thresh_i),
    .window_i     (window_i),
`ifdef SEQ_DET_IRQ_EN
    .irq_clr_i    (irq_clr_i),
    .irq_o        (irq_o),
`endif
    .z_o          (z_o),
    .hit_cnt_o    (hit_cnt_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o)
  );

  typedef struct {
    logic        start, abort, w, v;
    logic [3:0]  pattern;
    logic        overlap;
    logic [7:0]  thresh;
    logic [15:0] window;
    logic        z, busy, done;
    logic [7:0]  hit;
    logic        timeout;
  } vec_t;

  vec_t        vecs[$];
  logic [3:0]  cur_pat;
  logic        cur_ovl;
  logic [7:0]  cur_thr;
  logic [15:0] cur_win;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg(input logic [3:0] p, input logic o, input logic [7:0] t, input logic [15:0] win);
    cur_pat = p; cur_ovl = o; cur_thr = t; cur_win = win;
  endtask

  // Row: inputs held for one cycle, outputs expected during that same cycle.
  task automatic add(input logic s, input logic a, input logic w, input logic v,
                     input logic z, input logic b, input logic d,
                     input logic [7:0] h, input logic t);
    vec_t r;
    r.start = s; r.abort = a; r.w = w; r.v = v;
    r.pattern = cur_pat; r.overlap = cur_ovl; r.thresh = cur_thr; r.window = cur_win;
    r.z = z; r.busy = b; r.done = d; r.hit = h; r.timeout = t;
    vecs.push_back(r);
  endtask

  task automatic check_all(input string tag, input logic z, input logic b,
                           input logic d, input logic [7:0] h, input logic t);
    check({tag, " z"},       z_o,       z);
    check({tag, " busy"},    busy_o,    b);
    check({tag, " done"},    done_o,    d);
    check({tag, " hit_cnt"}, hit_cnt_o, h);
    check({tag, " timeout"}, timeout_o, t);
  endtask

  task automatic drive(input logic s, input logic a, input logic w, input logic v);
    @(negedge clk);
    start_i = s; abort_i = a; w_i = w; w_valid_i = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start_i = 0; abort_i = 0; w_i = 0; w_valid_i = 0; overlap_i = 0;
    pattern_i = '0; hit_thresh_i = '0; window_i = '0;
`ifdef SEQ_DET_IRQ_EN
    irq_clr_i = 1'b0;
`endif

    // Overlapping 1010 on 1,0,1,0,1,0: hits on bits 4 and 6, then abort.
    cfg(4'b1010, 1'b1, 8'd0, 16'd0);
    add(1,0,0,1, 0,0,0,8'd0,0);
    add(0,0,1,1, 0,1,0,8'd0,0);
    add(0,0,0,1, 0,1,0,8'd0,0);
    add(0,0,1,1, 0,1,0,8'd0,0);
    add(0,0,0,1, 1,1,0,8'd0,0);
    add(0,0,1,1, 0,1,0,8'd1,0);
    add(0,0,0,1, 1,1,0,8'd1,0);
    add(0,1,0,0, 0,1,0,8'd2,0);
    add(0,0,0,0, 0,0,0,8'd2,0);
    // Non-overlapping: only bit 4 hits.
    cfg(4'b1010, 1'b0, 8'd0, 16'd0);
    add(1,0,0,0, 0,0,0,8'd2,0);
    add(0,0,1,1, 0,1,0,8'd0,0);
    add(0,0,0,1, 0,1,0,8'd0,0);
    add(0,0,1,1, 0,1,0,8'd0,0);
    add(0,0,0,1, 1,1,0,8'd0,0);
    add(0,0,1,1, 0,1,0,8'd1,0);
    add(0,0,0,1, 0,1,0,8'd1,0);
    add(0,1,0,0, 0,1,0,8'd1,0);
    add(0,0,0,0, 0,0,0,8'd1,0);
    // Threshold 2; pattern inputs changed mid-run must be ignored.
    cfg(4'b1010, 1'b1, 8'd2, 16'd0);
    add(1,0,0,0, 0,0,0,8'd1,0);
    cfg(4'b0101, 1'b0, 8'd0, 16'd0);
    add(0,0,1,1, 0,1,0,8'd0,0);
    add(0,0,0,1, 0,1,0,8'd0,0);
    add(0,0,1,1, 0,1,0,8'd0,0);
    add(0,0,0,1, 1,1,0,8'd0,0);
    add(0,0,1,1, 0,1,0,8'd1,0);
    add(0,0,0,1, 1,1,0,8'd1,0);
    add(1,1,0,0, 0,0,1,8'd2,0);
    add(0,0,0,0, 0,0,0,8'd2,0);
    // Window 5 with all zeros: exactly 5 busy cycles, then timeout.
    cfg(4'b1010, 1'b1, 8'd0, 16'd5);
    add(1,0,0,0, 0,0,0,8'd2,0);
    for (int i = 0; i < 5; i++) add(0,0,0,1, 0,1,0,8'd0,0);
    add(0,0,0,0, 0,0,1,8'd0,1);
    add(0,0,0,0, 0,0,0,8'd0,1);
    // Window 5, threshold 1, hit on the 5th cycle: threshold wins.
    cfg(4'b1010, 1'b1, 8'd1, 16'd5);
    add(1,0,0,0, 0,0,0,8'd0,1);
    add(0,0,0,1, 0,1,0,8'd0,0);
    add(0,0,1,1, 0,1,0,8'd0,0);
    add(0,0,0,1, 0,1,0,8'd0,0);
    add(0,0,1,1, 0,1,0,8'd0,0);
    add(0,0,0,1, 1,1,0,8'd0,0);
    add(0,0,0,0, 0,0,1,8'd1,0);
    add(0,0,0,0, 0,0,0,8'd1,0);
    // w_valid gaps: only the 4th valid bit completes 1010; then abort.
    cfg(4'b1010, 1'b1, 8'd0, 16'd0);
    add(1,0,0,0, 0,0,0,8'd1,0);
    add(0,0,1,1, 0,1,0,8'd0,0);
    add(0,0,0,0, 0,1,0,8'd0,0);
    add(0,0,0,1, 0,1,0,8'd0,0);
    add(0,0,1,0, 0,1,0,8'd0,0);
    add(0,0,1,1, 0,1,0,8'd0,0);
    add(0,0,0,0, 0,1,0,8'd0,0);
    add(0,0,0,1, 1,1,0,8'd0,0);
    add(0,0,0,0, 0,1,0,8'd1,0);
    add(1,1,0,0, 0,1,0,8'd1,0);
    add(0,0,0,0, 0,0,0,8'd1,0);
    add(1,1,0,0, 0,0,0,8'd1,0);
    add(0,0,0,1, 0,0,0,8'd1,0);

    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
`ifdef SEQ_DET_IRQ_EN
    check("reset irq", irq_o, 1'b0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      start_i = vecs[i].start; abort_i = vecs[i].abort;
      w_i = vecs[i].w; w_valid_i = vecs[i].v;
      pattern_i = vecs[i].pattern; overlap_i = vecs[i].overlap;
      hit_thresh_i = vecs[i].thresh; window_i = vecs[i].window;
      #1;
      check_all($sformatf("row%0d", i), vecs[i].z, vecs[i].busy,
                vecs[i].done, vecs[i].hit, vecs[i].timeout);
    end

`ifdef SEQ_DET_IRQ_EN
    drive(0, 0, 0, 0);
    #1 check("irq set", irq_o, 1'b1);
    irq_clr_i = 1'b1;
    @(negedge clk);
    irq_clr_i = 1'b0;
    #1 check("irq cleared", irq_o, 1'b0);
`endif

    // Asynchronous reset in the middle of a run with a hit in flight.
    pattern_i = 4'b1010; overlap_i = 1'b1; hit_thresh_i = '0; window_i = '0;
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    drive(0, 0, 0, 1);
    #1;
    check_all("pre_reset", 1'b1, 1'b1, 1'b0, 8'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    w_valid_i = 1'b0;
    #1;
    check_all("post_reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Run controller for the shared serial pattern detector. It arms a programmable PAT_W-bit Mealy pattern match on the serial stream `w` in overlapping or non-overlapping mode, and counts hits. It ends the run either when a hit threshold is reached or when a cycle window expires, and reports why the run ended. It sits between the host control registers and the serial input, and it replaces the fixed-pattern 1010 detector for runtime-configurable runs.

## Interface
- PAT_W, 4, pattern length in bits (≥2)
- CNT_W, 8, hit counter width
- WIN_W, 16, window timer width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a run (sampled in IDLE only)
- abort  in  1  cancel the current run
- w  in  1  serial data bit
- w_valid  in  1  `w` is valid this cycle
- pattern  in  PAT_W  match pattern; MSB is the oldest bit
- overlap  in  1  1 = overlapping match, 0 = non-overlapping match
- hit_thresh  in  CNT_W  hits that end the run; 0 = no count limit
- window  in  WIN_W  run length in cycles; 0 = unlimited
- z  out  1  Mealy hit flag, combinational
- hit_cnt  out  CNT_W  hits in the current or last run
- busy  out  1  state is RUN
- done  out  1  one-cycle end-of-run pulse
- timeout  out  1  last run ended by window expiry

## Operation
- Outputs at reset: z=0, hit_cnt=0, busy=0, done=0, timeout=0. State resets to IDLE. Internal history, fill count and timer reset to 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1, abort=0: at the next edge:
  - latch pattern, overlap, hit_thresh, window;
  - clear history, fill count, hit_cnt, timeout;
  - load the timer with `window`;
  - go to RUN.
- RUN, on a w_valid cycle:
  - match = (fill ≥ PAT_W-1) and ({history[PAT_W-2:0], w} == latched pattern);
  - z = match in the same cycle. z is 0 outside RUN and on cycles with w_valid=0.
  - On the edge, `w` shifts into history and fill increments, saturating at PAT_W-1.
  - On a match, hit_cnt increments, saturating at all-ones.
  - In non-overlap mode, a match also clears fill. A new match then needs PAT_W fresh bits.
- RUN timer: when latched window ≠ 0, the timer decrements on every cycle, whatever w_valid is.
- RUN termination, with priority from highest to lowest:
  1. abort: go to IDLE with no done pulse; hit_cnt holds; timeout=0.
  2. Threshold: hit_thresh ≠ 0 and the incremented hit_cnt == hit_thresh. Go to DONE with timeout=0.
  3. Window expiry: the timer is 1 and decrementing. Go to DONE with timeout=1.
  - When threshold and expiry fall on the same cycle, threshold wins (timeout=0).
- DONE: done=1 for exactly one cycle, then IDLE. hit_cnt and timeout hold until the next start.
- start is ignored in RUN and DONE. abort in IDLE or DONE has no effect. start and abort together in IDLE: stay in IDLE.
- Pattern inputs are read only at start. Changing them mid-run has no effect.
- Reset asserted mid-run forces IDLE and clears all outputs immediately (asynchronous reset).

## Timing
- z is combinational from `w`, `w_valid` and registered state: zero latency.
- hit_cnt updates on the edge that closes the hit cycle.
- busy rises on the edge after start is sampled and falls on the terminating edge.
- done is registered: high in the cycle after the terminating edge.
- Minimum start-to-start spacing is 3 cycles: RUN ≥1 cycle, DONE 1 cycle, IDLE 1 cycle.
- window=N gives exactly N RUN cycles when no earlier termination occurs.

## Configuration
- SEQ_DET_IRQ_EN defined:
  - adds input `irq_clr` (1 bit) and output `irq` (1 bit, reset 0);
  - irq sets on every done pulse and stays set until an irq_clr cycle;
  - when set and clear fall on the same cycle, set wins.
- SEQ_DET_IRQ_EN undefined: neither port exists. Only `done` signals the end of a run.

## Test plan
- Pattern 1010, overlap=1, thresh=0, window=0. Stream 1,0,1,0,1,0 with w_valid=1 → z=1 on bits 4 and 6; hit_cnt=2; busy stays 1.
- Same stream with overlap=0 → z=1 on bit 4 only; hit_cnt=1.
- Pattern 1010, overlap=1, thresh=2. Stream 1,0,1,0,1,0 → done pulses in the cycle after bit 6; timeout=0; hit_cnt=2; then IDLE.
- window=5, stream all zeros → busy for exactly 5 cycles; done then pulses with timeout=1 and hit_cnt=0. Then repeat with thresh=1 and pattern completing in the 5th cycle → timeout=0.
- w_valid toggling 1,0 during 1,0,1,0 → z only on the 4th valid bit. Then abort mid-run → IDLE, no done, hit_cnt held.
- Reset pulled low mid-run → all outputs 0 immediately. With SEQ_DET_IRQ_EN: irq=1 after done, cleared by irq_clr.
